// File: rtl/stage_id_interlock.sv
// ID stage: RV32I/RV64I decode, immediate generation, write-first regfile read and
// a valid/ready output register with a load-use interlock toward EXE.
module stage_id_interlock #(
   parameter int XLEN       = 64,
   parameter int LOAD_DELAY = 1,
   parameter int WB_REFRESH = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [4:0]      out_rd,
   output logic            out_rd_en,
   output logic            out_mem_read,
   output logic            out_ri,
   input  logic            wb_rd_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_result
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("stage_id_interlock: XLEN must be 32 or 64");
   end

   localparam bit IS64 = (XLEN == 64);
   localparam int CW   = (LOAD_DELAY < 1) ? 1 : $clog2(LOAD_DELAY + 1);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            sh_l_ok, sh_r_ok;
   logic            legal, d_rs1_en, d_rs2_en, d_rd_we, d_mem, d_rd_en;
   logic [XLEN-1:0] d_imm, rd1_val, rd2_val;

   logic [XLEN-1:0] regs [0:31];
   logic [4:0]      rs1_q, rs2_q;
   logic [CW-1:0]   stall_cnt;
   logic [4:0]      stall_rd;
   logic            hazard, in_fire, out_fire;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];
   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];

   assign imm_i = XLEN'($signed(in_instr[31:20]));
   assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

   // RV64 shamt is 6 bits, so only instr[31:26] carries the funct field there
   assign sh_l_ok = IS64 ? (in_instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
   assign sh_r_ok = IS64 ? (in_instr[31:26] == 6'b000000 || in_instr[31:26] == 6'b010000)
                         : (f7 == 7'b0000000 || f7 == 7'b0100000);

   always_comb begin
      legal    = 1'b0;
      d_rs1_en = 1'b0;
      d_rs2_en = 1'b0;
      d_rd_we  = 1'b0;
      d_mem    = 1'b0;
      d_imm    = '0;
      case (opc)
         OP_LUI, OP_AUIPC: begin
            legal = 1'b1; d_rd_we = 1'b1; d_imm = imm_u;
         end
         OP_JAL: begin
            legal = 1'b1; d_rd_we = 1'b1; d_imm = imm_j;
         end
         OP_JALR: begin
            legal = (f3 == 3'b000); d_rs1_en = 1'b1; d_rd_we = 1'b1; d_imm = imm_i;
         end
         OP_BRANCH: begin
            legal = (f3 != 3'b010) && (f3 != 3'b011);
            d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_imm = imm_b;
         end
         OP_LOAD: begin
            legal = (f3 != 3'b111) && (IS64 || (f3 != 3'b011 && f3 != 3'b110));
            d_rs1_en = 1'b1; d_rd_we = 1'b1; d_mem = 1'b1; d_imm = imm_i;
         end
         OP_STORE: begin
            legal = !f3[2] && (IS64 || f3 != 3'b011);
            d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_imm = imm_s;
         end
         OP_IMM: begin
            legal = (f3 == 3'b001) ? sh_l_ok : (f3 == 3'b101) ? sh_r_ok : 1'b1;
            d_rs1_en = 1'b1; d_rd_we = 1'b1; d_imm = imm_i;
         end
         OP_REG: begin
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_rd_we = 1'b1;
         end
         OP_IMM32: begin
            legal = IS64 && (f3 == 3'b000 || (f3 == 3'b001 && f7 == 7'b0000000) ||
                             (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)));
            d_rs1_en = 1'b1; d_rd_we = 1'b1; d_imm = imm_i;
         end
         OP_REG32: begin
            legal = IS64 && ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_rd_we = 1'b1;
         end
         default: ;
      endcase
      // Illegal encodings use no operands, so they can never trip the interlock
      if (!legal) begin
         d_rs1_en = 1'b0;
         d_rs2_en = 1'b0;
         d_rd_we  = 1'b0;
         d_mem    = 1'b0;
         d_imm    = '0;
      end
   end

   assign d_rd_en = d_rd_we && (rd != 5'd0);

   always_comb begin
      rd1_val = '0;
      rd2_val = '0;
      if (d_rs1_en && rs1 != 5'd0)
         rd1_val = (wb_rd_en && wb_rd == rs1) ? wb_result : regs[rs1];
      if (d_rs2_en && rs2 != 5'd0)
         rd2_val = (wb_rd_en && wb_rd == rs2) ? wb_result : regs[rs2];
   end

   assign hazard = (stall_cnt != '0) && (stall_rd != 5'd0) &&
                   ((d_rs1_en && rs1 == stall_rd) || (d_rs2_en && rs2 == stall_rd));
   assign in_ready = !id_flush && !hazard && (!out_valid || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_rd_en && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_imm      <= '0;
         out_rs1_val  <= '0;
         out_rs2_val  <= '0;
         out_rd       <= '0;
         out_rd_en    <= 1'b0;
         out_mem_read <= 1'b0;
         out_ri       <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
      end else if (id_flush) begin
         out_valid <= 1'b0;
      end else if (in_fire) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_imm      <= d_imm;
         out_rs1_val  <= rd1_val;
         out_rs2_val  <= rd2_val;
         out_rd       <= rd;
         out_rd_en    <= d_rd_en;
         out_mem_read <= d_mem;
         out_ri       <= !legal;
         rs1_q        <= d_rs1_en ? rs1 : 5'd0;
         rs2_q        <= d_rs2_en ? rs2 : 5'd0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else if (WB_REFRESH != 0 && out_valid && wb_rd_en && wb_rd != 5'd0) begin
         // Held operands track WB so EXE never sees a stale value after backpressure
         if (wb_rd == rs1_q) out_rs1_val <= wb_result;
         if (wb_rd == rs2_q) out_rs2_val <= wb_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         stall_rd  <= '0;
      end else if (id_flush) begin
         stall_cnt <= '0;
      end else if (out_fire && out_mem_read && out_rd_en) begin
         stall_cnt <= CW'(LOAD_DELAY);
         stall_rd  <= out_rd;
      end else if (out_ready && stall_cnt != '0) begin
         stall_cnt <= stall_cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_stage_id_interlock.sv
// Directed bench for stage_id_interlock: XLEN=64 instance driven through a scoreboard,
// plus an XLEN=32 instance for the RV32-only decode rules.
module tb_stage_id_interlock;

   typedef struct packed {
      logic [63:0] pc, imm, rs1v, rs2v;
      logic [4:0]  rd;
      logic        rd_en, mr, ri;
   } exp_t;

   logic clk, rst;
   // XLEN=64 instance
   logic        id_flush, in_valid, in_ready, out_ready, wb_rd_en;
   logic [63:0] in_pc, wb_result;
   logic [31:0] in_instr;
   logic [4:0]  wb_rd;
   logic        o_valid, o_rd_en, o_mr, o_ri;
   logic [63:0] o_pc, o_imm, o_rs1, o_rs2;
   logic [4:0]  o_rd;
   // XLEN=32 instance
   logic        s_in_valid, s_in_ready, s_out_ready;
   logic [31:0] s_in_pc, s_in_instr;
   logic        s_valid, s_rd_en, s_mr, s_ri;
   logic [31:0] s_pc, s_imm, s_rs1, s_rs2;
   logic [4:0]  s_rd;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   stage_id_interlock #(.XLEN(64), .LOAD_DELAY(1), .WB_REFRESH(1)) dut64 (
      .clk(clk), .rst(rst), .id_flush(id_flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(o_valid), .out_ready(out_ready), .out_pc(o_pc), .out_imm(o_imm),
      .out_rs1_val(o_rs1), .out_rs2_val(o_rs2), .out_rd(o_rd), .out_rd_en(o_rd_en),
      .out_mem_read(o_mr), .out_ri(o_ri),
      .wb_rd_en(wb_rd_en), .wb_rd(wb_rd), .wb_result(wb_result)
   );

   stage_id_interlock #(.XLEN(32), .LOAD_DELAY(1), .WB_REFRESH(1)) dut32 (
      .clk(clk), .rst(rst), .id_flush(1'b0),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(s_in_pc), .in_instr(s_in_instr),
      .out_valid(s_valid), .out_ready(s_out_ready), .out_pc(s_pc), .out_imm(s_imm),
      .out_rs1_val(s_rs1), .out_rs2_val(s_rs2), .out_rd(s_rd), .out_rd_en(s_rd_en),
      .out_mem_read(s_mr), .out_ri(s_ri),
      .wb_rd_en(1'b0), .wb_rd(5'd0), .wb_result(32'd0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] r1,
                       input logic [63:0] r2, input logic [4:0] rd, input logic rd_en,
                       input logic mr, input logic ri);
      exp_t e;
      e.pc = pc; e.imm = imm; e.rs1v = r1; e.rs2v = r2;
      e.rd = rd; e.rd_en = rd_en; e.mr = mr; e.ri = ri;
      sb.push_back(e);
   endtask

   // Compare any consuming handshake against the scoreboard, then advance one cycle.
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      if (!rst && o_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_output", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("out_pc", o_pc, e.pc);
            chk("out_imm", o_imm, e.imm);
            chk("out_rs1_val", o_rs1, e.rs1v);
            chk("out_rs2_val", o_rs2, e.rs2v);
            chk("out_rd", 64'(o_rd), 64'(e.rd));
            chk("out_rd_en", 64'(o_rd_en), 64'(e.rd_en));
            chk("out_mem_read", 64'(o_mr), 64'(e.mr));
            chk("out_ri", 64'(o_ri), 64'(e.ri));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; id_flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
      out_ready = 1'b1; wb_rd_en = 1'b0; wb_rd = '0; wb_result = '0;
      s_in_valid = 1'b0; s_in_pc = '0; s_in_instr = '0; s_out_ready = 1'b1;
      cyc(); cyc();
      rst = 1'b0; #1;
      chk("rst_out_valid", 64'(o_valid), 64'd0);
      chk("rst_out_pc", o_pc, 64'd0);
      chk("rst_out_imm", o_imm, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst32_out_valid", 64'(s_valid), 64'd0);

      // back-to-back with write-first bypass of x1
      cyc(); in_valid = 1'b1; in_pc = 64'h100; in_instr = 32'h00500093;
      push(64'h100, 64'd5, 64'd0, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0);
      #1 chk("t2_in_ready_a", 64'(in_ready), 64'd1);
      cyc(); in_pc = 64'h104; in_instr = 32'h00108133;
      wb_rd_en = 1'b1; wb_rd = 5'd1; wb_result = 64'd5;
      push(64'h104, 64'd0, 64'd5, 64'd5, 5'd2, 1'b1, 1'b0, 1'b0);
      #1 chk("t2_in_ready_b", 64'(in_ready), 64'd1);
      chk("t2_out_valid", 64'(o_valid), 64'd1);
      cyc(); in_valid = 1'b0; wb_rd_en = 1'b0;
      #1 chk("t2_add_valid", 64'(o_valid), 64'd1);

      // load-use: ld x3 issues, dependent addi x5,x3,1 waits one cycle
      cyc(); in_valid = 1'b1; in_pc = 64'h200; in_instr = 32'h00023183;
      push(64'h200, 64'd0, 64'd0, 64'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      cyc(); in_valid = 1'b0;
      #1 chk("t3_ld_mem_read", 64'(o_mr), 64'd1);
      cyc(); in_valid = 1'b1; in_pc = 64'h204; in_instr = 32'h00118293;
      wb_rd_en = 1'b1; wb_rd = 5'd3; wb_result = 64'h77;
      push(64'h204, 64'd1, 64'h77, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      #1 chk("t3_stall_in_ready", 64'(in_ready), 64'd0);
      chk("t3_bubble", 64'(o_valid), 64'd0);
      cyc(); wb_rd_en = 1'b0;
      #1 chk("t3_release_in_ready", 64'(in_ready), 64'd1);
      cyc(); in_valid = 1'b0;
      #1 chk("t3_addi_valid", 64'(o_valid), 64'd1);

      // backpressure with WB refresh of a held operand
      cyc(); in_valid = 1'b1; in_pc = 64'h300; in_instr = 32'h00038333;
      push(64'h300, 64'd0, 64'hAB, 64'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      #1 chk("t4_in_ready_a", 64'(in_ready), 64'd1);
      cyc(); in_pc = 64'h304; in_instr = 32'hFFF00093; out_ready = 1'b0;
      wb_rd_en = 1'b1; wb_rd = 5'd7; wb_result = 64'hAB;
      #1 chk("t4_bp_in_ready", 64'(in_ready), 64'd0);
      chk("t4_pre_refresh", o_rs1, 64'd0);
      cyc(); wb_rd = 5'd0; wb_result = 64'h55;
      #1 chk("t4_refresh_rs1", o_rs1, 64'hAB);
      chk("t4_hold_pc", o_pc, 64'h300);
      chk("t4_hold_rd", 64'(o_rd), 64'd6);
      chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
      chk("t4_hold_valid", 64'(o_valid), 64'd1);
      cyc(); wb_rd_en = 1'b0;
      #1 chk("t4_x0_no_refresh", o_rs2, 64'd0);
      out_ready = 1'b1;
      push(64'h304, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0);

      // flush during a load-use stall held by backpressure
      cyc(); in_pc = 64'h400; in_instr = 32'h00823183;
      push(64'h400, 64'd8, 64'd0, 64'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      #1 chk("t5_ld_in_ready", 64'(in_ready), 64'd1);
      cyc(); in_valid = 1'b0;
      cyc(); in_valid = 1'b1; in_pc = 64'h404; in_instr = 32'h00118293; out_ready = 1'b0;
      #1 chk("t5_stall_a", 64'(in_ready), 64'd0);
      chk("t5_bubble", 64'(o_valid), 64'd0);
      cyc();
      #1 chk("t5_stall_no_decrement", 64'(in_ready), 64'd0);
      id_flush = 1'b1;
      #1 chk("t5_flush_in_ready", 64'(in_ready), 64'd0);
      cyc(); id_flush = 1'b0;
      #1 chk("t5_after_flush_in_ready", 64'(in_ready), 64'd1);
      chk("t5_after_flush_valid", 64'(o_valid), 64'd0);
      push(64'h404, 64'd1, 64'h77, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      cyc(); in_valid = 1'b0;
      #1 chk("t5_dep_valid", 64'(o_valid), 64'd1);
      out_ready = 1'b1;

      // decode corner cases on both widths
      cyc(); in_valid = 1'b1; in_pc = 64'h500; in_instr = 32'h00100013;
      push(64'h500, 64'd1, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      s_in_valid = 1'b1; s_in_pc = 32'h10; s_in_instr = 32'h0010809B;
      cyc(); in_pc = 64'h504; in_instr = 32'h0000007F;
      push(64'h504, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      s_in_pc = 32'h14; s_in_instr = 32'h800000B7;
      #1 chk("t6_addiw_valid", 64'(s_valid), 64'd1);
      chk("t6_addiw_ri", 64'(s_ri), 64'd1);
      chk("t6_addiw_rd_en", 64'(s_rd_en), 64'd0);
      chk("t6_addiw_imm", 64'(s_imm), 64'd0);
      cyc(); in_pc = 64'h508; in_instr = 32'h800000B7;
      push(64'h508, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0);
      s_in_pc = 32'h18; s_in_instr = 32'h02009093;
      #1 chk("t6_lui_imm32", 64'(s_imm), 64'h8000_0000);
      chk("t6_lui_rd_en", 64'(s_rd_en), 64'd1);
      chk("t6_lui_ri", 64'(s_ri), 64'd0);
      cyc(); in_pc = 64'h50C; in_instr = 32'h02009093;
      push(64'h50C, 64'd32, 64'd5, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0);
      s_in_pc = 32'h1C; s_in_instr = 32'h01F09093;
      #1 chk("t6_slli32_bit25_ri", 64'(s_ri), 64'd1);
      chk("t6_slli32_bit25_rd_en", 64'(s_rd_en), 64'd0);
      cyc(); in_valid = 1'b0; s_in_valid = 1'b0;
      #1 chk("t6_slli31_ri", 64'(s_ri), 64'd0);
      chk("t6_slli31_imm", 64'(s_imm), 64'd31);
      chk("t6_slli31_rd_en", 64'(s_rd_en), 64'd1);

      // reset asserted mid-stream while an instruction is held
      cyc(); in_valid = 1'b1; in_pc = 64'h600; in_instr = 32'h00038333; out_ready = 1'b0;
      cyc(); in_valid = 1'b0;
      #1 chk("t1_held_valid", 64'(o_valid), 64'd1);
      chk("t1_held_rs1", o_rs1, 64'hAB);
      chk("t1_held_pc", o_pc, 64'h600);
      rst = 1'b1;
      #1 chk("t1_async_valid", 64'(o_valid), 64'd0);
      chk("t1_async_pc", o_pc, 64'd0);
      chk("t1_async_rs1", o_rs1, 64'd0);
      chk("t1_async_rd_en", 64'(o_rd_en), 64'd0);
      cyc(); rst = 1'b0;
      #1 chk("t1_post_in_ready", 64'(in_ready), 64'd1);
      chk("t1_post_valid", 64'(o_valid), 64'd0);
      in_valid = 1'b1; in_pc = 64'h610; in_instr = 32'h00038333; out_ready = 1'b1;
      push(64'h610, 64'd0, 64'd0, 64'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      cyc(); in_valid = 1'b0;
      #1 chk("t1_regs_cleared_valid", 64'(o_valid), 64'd1);
      cyc();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
